// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Top-level control unit: drives the fetch controller, decodes each fetched
//   instruction, starts exactly one execution FSM (ALU, MOV or LDI) and holds
//   its start level until that FSM reports done, then pulses clear_sub and
//   counts the retired instruction.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   run                           execution enable (sampled in IDLE/CLEAR)
//   fetch_start / fetch_done      level request / completion of fetch
//   instr[15:0]                   {opcode, p1, p2}, valid with fetch_done
//   parameter1/2[5:0], subop[1:0] latched operand selects and ALU function
//   alu/mov/ldi_start, *_done     execution FSM handshakes
//   clear_sub                     one-cycle return-to-idle pulse
//   busy, halted, err             status
//   instr_count[CNTW-1:0]         retired-instruction counter (wraps)
module instr_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            fetch_start,
    input  logic            fetch_done,
    input  logic [15:0]     instr,
    output logic [5:0]      parameter1,
    output logic [5:0]      parameter2,
    output logic [1:0]      subop,
    output logic            alu_start,
    output logic            mov_start,
    output logic            ldi_start,
    input  logic            alu_done,
    input  logic            mov_done,
    input  logic            ldi_done,
    output logic            clear_sub,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [CNTW-1:0] instr_count
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_CLEAR, S_HALT, S_ERR
    } state_t;

    typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_MOV, SEL_LDI} sel_t;

    state_t        state, state_d;
    sel_t          sel, sel_d;
    logic [3:0]    opcode;
    logic [WW-1:0] wait_cnt;
    logic          wait_inc;
    logic          sel_done;
    logic          p1_ok, p2_ok;

    assign p1_ok = (parameter1 <= 6'd4);
    assign p2_ok = (parameter2 <= 6'd4);

    // Only the done of the recorded FSM is honoured.
    always_comb begin
        sel_done = 1'b0;
        case (sel)
            SEL_ALU: sel_done = alu_done;
            SEL_MOV: sel_done = mov_done;
            SEL_LDI: sel_done = ldi_done;
            default: sel_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state;
        sel_d    = sel;
        wait_inc = 1'b0;
        case (state)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: begin
                // done wins over a timeout in the same cycle
                if (fetch_done)                          state_d = S_DECODE;
                else if (wait_cnt == WW'(TIMEOUT - 1))   state_d = S_ERR;
                else                                     wait_inc = 1'b1;
            end
            S_DECODE: begin
                sel_d   = SEL_NONE;
                state_d = S_ERR;
                casez (opcode)
                    4'b0000: state_d = S_CLEAR;
                    4'b1111: state_d = S_HALT;
                    4'b0001: if (p1_ok && p2_ok) begin state_d = S_EXEC; sel_d = SEL_MOV; end
                    4'b0010: if (p1_ok)          begin state_d = S_EXEC; sel_d = SEL_LDI; end
                    4'b01??: if (p1_ok && p2_ok) begin state_d = S_EXEC; sel_d = SEL_ALU; end
                    default: state_d = S_ERR;
                endcase
            end
            S_EXEC: begin
                if (sel_done)                            state_d = S_CLEAR;
                else if (wait_cnt == WW'(TIMEOUT - 1))   state_d = S_ERR;
                else                                     wait_inc = 1'b1;
            end
            S_CLEAR: state_d = run ? S_FETCH : S_IDLE;
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register without a combinational decode on the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            sel         <= SEL_NONE;
            wait_cnt    <= '0;
            opcode      <= '0;
            parameter1  <= '0;
            parameter2  <= '0;
            subop       <= '0;
            instr_count <= '0;
            fetch_start <= 1'b0;
            alu_start   <= 1'b0;
            mov_start   <= 1'b0;
            ldi_start   <= 1'b0;
            clear_sub   <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_d;
            sel   <= sel_d;

            // Any state change restarts the wait count, which covers entry
            // to FETCH and EXEC.
            if (state_d != state) wait_cnt <= '0;
            else if (wait_inc)    wait_cnt <= wait_cnt + WW'(1);

            if (state == S_FETCH && fetch_done) begin
                opcode     <= instr[15:12];
                parameter1 <= instr[11:6];
                parameter2 <= instr[5:0];
                subop      <= (instr[15:14] == 2'b01) ? instr[13:12] : 2'b00;
            end

            if (state_d == S_CLEAR) instr_count <= instr_count + CNTW'(1);

            fetch_start <= (state_d == S_FETCH);
            alu_start   <= (state_d == S_EXEC) && (sel_d == SEL_ALU);
            mov_start   <= (state_d == S_EXEC) && (sel_d == SEL_MOV);
            ldi_start   <= (state_d == S_EXEC) && (sel_d == SEL_LDI);
            clear_sub   <= (state_d == S_CLEAR);
            busy        <= !(state_d inside {S_IDLE, S_HALT, S_ERR});
            halted      <= (state_d == S_HALT) || (state_d == S_ERR);
            err         <= (state_d == S_ERR);
        end
    end
endmodule
